hdb3_tx_ctrl: RTL and testbench
===============================

// Module: hdb3_tx_ctrl
// PURPOSE
//   Transmit scheduler that sequences the HDB3 encoder datapath. Accepts parallel
//   words over a valid/ready stream and serialises them MSB-first onto the
//   encoder's data_in/en inputs, one bit per clk. Fills idle slots and flushes
//   the encoder pipeline on stop. Delays framing markers by the encoder latency
//   so they line up with bp/bn at the encoder output.
// PARAMETERS
//   DATA_W    8    word width; one slot = DATA_W clk cycles
//   ENC_LAT   4    clk cycles from encoder data_in sample to bp/bn valid
//   IDLE_BIT  1'b1 bit value sent in idle and underrun slots (AIS-style ones)
//   CNT_W     16   width of the saturating underrun counter
// PORTS
//   clk          in   1        single clock, rising edge
//   rst          in   1        asynchronous, active-high reset
//   tx_enable    in   1        level; request to run the line
//   s_data       in   DATA_W   word to send
//   s_valid      in   1        s_data valid
//   s_last       in   1        word is the last of a frame (qualified by s_valid)
//   s_ready      out  1        controller accepts a word this cycle
//   enc_data_in  out  1        to encoder data_in (registered)
//   enc_en       out  1        to encoder en (registered)
//   line_valid   out  1        enc_en delayed ENC_LAT cycles (bp/bn meaningful)
//   line_sof     out  1        first bit of a frame, delayed ENC_LAT cycles
//   busy         out  1        state != OFF
//   underrun     out  1        1-cycle pulse: mid-frame slot with no word available
//   underrun_cnt out  CNT_W    saturating count of underrun pulses
// BEHAVIOUR
// - Reset (async, at any time, including mid-frame): state=OFF. All outputs are 0,
//   counters are 0, and the delay lines are cleared. The partial frame is dropped.
// - States: OFF, ARM, IDLE, SEND, FLUSH. bit_cnt runs 0..DATA_W-1 in IDLE/SEND.
//   - OFF: enc_en=0, s_ready=0. If tx_enable=1 -> ARM.
//   - ARM (1 cycle): enc_en=0, s_ready=1. On handshake -> SEND. Otherwise -> IDLE.
//     bit_cnt is set to 0.
//   - IDLE: enc_en=1, enc_data_in=IDLE_BIT.
//   - SEND: enc_en=1, enc_data_in=shift_reg MSB. Shift left each cycle.
//   - Slot end (bit_cnt==DATA_W-1) in IDLE/SEND:
//     - s_ready=1 iff (tx_enable=1 OR frame_open=1).
//     - If a handshake occurs, load shift_reg. The next slot is SEND.
//     - If frame_open=1 and there is no handshake: next slot is an IDLE_BIT fill.
//       underrun pulses in that slot-end cycle. frame_open stays 1.
//     - If frame_open=0, there is no handshake and tx_enable=0 -> FLUSH.
//     - If frame_open=0, there is no handshake and tx_enable=1 -> IDLE.
//   - s_ready=0 in every other cycle. s_valid held without ready is a stall and
//     has no effect.
//   - FLUSH: enc_en=1, enc_data_in=0 for exactly ENC_LAT cycles -> OFF. tx_enable is
//     ignored until OFF is reached.
// - frame_open:
//   - Set on a handshake with s_last=0.
//   - Cleared on a handshake with s_last=1 (that word is still sent in full).
//   - A single-word frame (s_last=1 at the first handshake) leaves it at 0.
// - sof marker: 1 on the first enc_en cycle of a word loaded while frame_open was 0.
// - Latency:
//   - Handshake at cycle T -> MSB on enc_data_in at T+1; LSB at T+DATA_W.
//   - line_valid and line_sof are ENC_LAT-stage shift registers of enc_en and sof.
// - tx_enable deasserted mid-frame: the frame completes through its s_last word.
//   Stop is then honoured at the next slot end with no handshake.
// - Simultaneous stop and handshake at a slot end: the handshake wins; the word is sent.
// - underrun_cnt: +1 per underrun pulse, saturates at all-ones, cleared only by rst.
// TESTING
// - Reset, then tx_enable=1 with no data -> ARM for 1 cycle. Then enc_en=1 with
//   enc_data_in=1 continuously. s_ready is high every 8th cycle.
// - Send 8'hA5 with s_last=1 accepted in ARM -> enc_data_in=1,0,1,0,0,1,0,1.
//   line_sof=1 exactly 5 cycles after the handshake (1+ENC_LAT).
// - Send a 3-word frame 8'h00,8'hFF,8'h81 back-to-back -> 24 contiguous data bits.
//   There is no fill between words, exactly one line_sof, and underrun_cnt=0.
// - Frame of 2 words with s_valid low at the first slot end -> one 8-bit fill of 1s.
//   underrun pulses once and underrun_cnt=1. The second word follows the fill.
// - Drop tx_enable mid-frame -> the frame completes, then 4 cycles of enc_data_in=0
//   with enc_en=1. Then OFF, with busy=0, enc_en=0 and line_valid=0 4 cycles later.
// - Assert rst during SEND -> all outputs 0 in the same cycle. After release, state
//   is OFF and nothing is sent until tx_enable is seen high.

Source files
------------

// File: rtl/hdb3_tx_ctrl.sv
// Transmit scheduler for the HDB3 encoder: serialises stream words MSB-first,
// fills idle/underrun slots, flushes the encoder on stop, and aligns framing markers.
module hdb3_tx_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ENC_LAT  = 4,
    parameter logic        IDLE_BIT = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              enc_data_in,
    output logic              enc_en,
    output logic              line_valid,
    output logic              line_sof,
    output logic              busy,
    output logic              underrun,
    output logic [CNT_W-1:0]  underrun_cnt
);

    localparam int unsigned BW = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
    localparam int unsigned FW = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_ARM,
        S_IDLE,
        S_SEND,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]       flush_cnt_q, flush_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                frame_open_q, frame_open_d;
    logic                enc_data_q, enc_data_d;
    logic                enc_en_q, enc_en_d;
    logic                sof_q, sof_d;
    logic [CNT_W-1:0]    ucnt_q, ucnt_d;
    logic [ENC_LAT-1:0]  lv_q;
    logic [ENC_LAT-1:0]  ls_q;
    logic                rdy;
    logic                urun;
    logic                load;
    logic                slot_end;

    assign slot_end = (bit_cnt_q == BW'(DATA_W - 1));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        shift_d      = shift_q;
        frame_open_d = frame_open_q;
        sof_d        = 1'b0;
        rdy          = 1'b0;
        urun         = 1'b0;
        load         = 1'b0;

        case (state_q)
            S_OFF: begin
                if (tx_enable) state_d = S_ARM;
            end
            S_ARM: begin
                rdy       = 1'b1;
                bit_cnt_d = '0;
                if (s_valid) begin
                    load    = 1'b1;
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE, S_SEND: begin
                if (slot_end) begin
                    bit_cnt_d = '0;
                    rdy       = tx_enable | frame_open_q;
                    // A pending handshake outranks both underrun fill and stop.
                    if (s_valid && rdy) begin
                        load    = 1'b1;
                        state_d = S_SEND;
                    end else if (frame_open_q) begin
                        urun    = 1'b1;
                        state_d = S_IDLE;
                    end else if (!tx_enable) begin
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (state_q == S_SEND) shift_d = shift_q << 1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FW'(ENC_LAT - 1)) state_d = S_OFF;
                else flush_cnt_d = flush_cnt_q + FW'(1);
            end
            default: state_d = S_OFF;
        endcase

        if (load) begin
            shift_d      = s_data;
            frame_open_d = ~s_last;
            sof_d        = ~frame_open_q;
        end

        enc_en_d = (state_d == S_IDLE) || (state_d == S_SEND) || (state_d == S_FLUSH);
        if (state_d == S_SEND)      enc_data_d = shift_d[DATA_W-1];
        else if (state_d == S_IDLE) enc_data_d = IDLE_BIT;
        else                        enc_data_d = 1'b0;

        ucnt_d = (urun && (ucnt_q != '1)) ? ucnt_q + CNT_W'(1) : ucnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_OFF;
            bit_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            shift_q      <= '0;
            frame_open_q <= 1'b0;
            enc_data_q   <= 1'b0;
            enc_en_q     <= 1'b0;
            sof_q        <= 1'b0;
            ucnt_q       <= '0;
            lv_q         <= '0;
            ls_q         <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            shift_q      <= shift_d;
            frame_open_q <= frame_open_d;
            enc_data_q   <= enc_data_d;
            enc_en_q     <= enc_en_d;
            sof_q        <= sof_d;
            ucnt_q       <= ucnt_d;
            lv_q[0]      <= enc_en_q;
            ls_q[0]      <= sof_q;
            for (int unsigned i = 1; i < ENC_LAT; i++) begin
                lv_q[i] <= lv_q[i-1];
                ls_q[i] <= ls_q[i-1];
            end
        end
    end

    assign s_ready      = rdy;
    assign underrun     = urun;
    assign enc_data_in  = enc_data_q;
    assign enc_en       = enc_en_q;
    assign line_valid   = lv_q[ENC_LAT-1];
    assign line_sof     = ls_q[ENC_LAT-1];
    assign busy         = (state_q != S_OFF);
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_hdb3_tx_ctrl.sv
// Directed bench for hdb3_tx_ctrl: idle fill, single/multi-word frames,
// underrun fill, stop with flush, and asynchronous reset mid-frame.
module tb_hdb3_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_enable;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        enc_data_in;
    logic        enc_en;
    logic        line_valid;
    logic        line_sof;
    logic        busy;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hdb3_tx_ctrl #(
        .DATA_W  (8),
        .ENC_LAT (4),
        .IDLE_BIT(1'b1),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_enable   (tx_enable),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .enc_data_in (enc_data_in),
        .enc_en      (enc_en),
        .line_valid  (line_valid),
        .line_sof    (line_sof),
        .busy        (busy),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the cycle in which s_ready is high.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_timeout"}, 32'(s_ready), 32'd1);
    endtask

    task automatic check_word(input string tag, input logic [7:0] w, input int k);
        chk({tag, "_en"}, 32'(enc_en), 32'd1);
        chk({tag, "_bit"}, 32'(enc_data_in), 32'(w[8-k]));
    endtask

    initial begin
        logic [7:0] words [3];
        int         sof_seen;
        int         n;

        rst = 1'b1; tx_enable = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_en", 32'(enc_en), 32'd0);
        chk("rst_data", 32'(enc_data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_lv", 32'(line_valid), 32'd0);
        chk("rst_cnt", 32'(underrun_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("off_busy", 32'(busy), 32'd0);

        // Idle line: ARM for one cycle, then continuous ones, ready every 8th cycle.
        tx_enable = 1'b1;
        @(negedge clk);
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_en", 32'(enc_en), 32'd0);
        chk("arm_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("idle_en", 32'(enc_en), 32'd1);
            chk("idle_bit", 32'(enc_data_in), 32'd1);
            chk("idle_ready", 32'(s_ready), 32'((i % 8) == 7));
        end
        tx_enable = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_stop_busy", 32'(busy), 32'd0);
        chk("idle_stop_en", 32'(enc_en), 32'd0);

        // Single-word frame accepted in ARM.
        tx_enable = 1'b1; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
        @(negedge clk);
        chk("a5_arm_ready", 32'(s_ready), 32'd1);
        chk("a5_arm_sof", 32'(line_sof), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_word("a5", 8'hA5, k);
            chk("a5_sof", 32'(line_sof), 32'(k == 5));
            if (k == 1) s_valid = 1'b0;
        end

        // Three-word frame back-to-back.
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h81;
        sof_seen = 0;
        s_valid = 1'b1; s_data = words[0]; s_last = 1'b0;
        wait_ready("f3");
        for (int w = 0; w < 3; w++) begin
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                check_word("f3", words[w], k);
                if (line_sof) sof_seen++;
                if (k == 8 && w < 2) chk("f3_slot_ready", 32'(s_ready), 32'd1);
                if (k == 1) begin
                    if (w < 2) begin
                        s_data = words[w+1];
                        s_last = (w == 1);
                    end else begin
                        s_valid = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (line_sof) sof_seen++;
        end
        chk("f3_sof_count", 32'(sof_seen), 32'd1);
        chk("f3_urun_cnt", 32'(underrun_cnt), 32'd0);

        // Two-word frame with an underrun between the words.
        s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0;
        wait_ready("ur");
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_word("ur_w0", 8'h3C, k);
            if (k == 1) s_valid = 1'b0;
        end
        chk("ur_slot_ready", 32'(s_ready), 32'd1);
        chk("ur_pulse", 32'(underrun), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_word("ur_fill", 8'hFF, k);
            if (k < 8) chk("ur_pulse_low", 32'(underrun), 32'd0);
            if (k == 1) begin
                s_valid = 1'b1; s_data = 8'hC3; s_last = 1'b1;
            end
        end
        chk("ur_fill_end_ready", 32'(s_ready), 32'd1);
        chk("ur_fill_end_urun", 32'(underrun), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_word("ur_w1", 8'hC3, k);
            if (k == 1) s_valid = 1'b0;
        end
        chk("ur_cnt", 32'(underrun_cnt), 32'd1);

        // Stop requested mid-frame: frame completes, then flush and OFF.
        s_valid = 1'b1; s_data = 8'hF0; s_last = 1'b0;
        wait_ready("stop");
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_word("stop_w0", 8'hF0, k);
            if (k == 1) begin
                tx_enable = 1'b0; s_data = 8'h0F; s_last = 1'b1;
            end
        end
        chk("stop_open_ready", 32'(s_ready), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_word("stop_w1", 8'h0F, k);
            if (k == 1) s_valid = 1'b0;
        end
        chk("stop_closed_ready", 32'(s_ready), 32'd0);
        for (int f = 0; f < 4; f++) begin
            @(negedge clk);
            chk("flush_en", 32'(enc_en), 32'd1);
            chk("flush_bit", 32'(enc_data_in), 32'd0);
            chk("flush_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("off_busy2", 32'(busy), 32'd0);
        chk("off_en2", 32'(enc_en), 32'd0);
        chk("off_lv_tail", 32'(line_valid), 32'd1);
        repeat (4) @(negedge clk);
        chk("off_lv", 32'(line_valid), 32'd0);
        chk("off_stays", 32'(busy), 32'd0);

        // Asynchronous reset during SEND.
        tx_enable = 1'b1; s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
        wait_ready("rs");
        @(negedge clk);
        s_valid = 1'b0;
        check_word("rs_w", 8'hAA, 1);
        @(negedge clk);
        check_word("rs_w", 8'hAA, 2);
        #1 rst = 1'b1; tx_enable = 1'b0;
        #1;
        chk("rs_en", 32'(enc_en), 32'd0);
        chk("rs_data", 32'(enc_data_in), 32'd0);
        chk("rs_ready", 32'(s_ready), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_lv", 32'(line_valid), 32'd0);
        chk("rs_sof", 32'(line_sof), 32'd0);
        chk("rs_urun", 32'(underrun), 32'd0);
        chk("rs_cnt", 32'(underrun_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rs_off_busy", 32'(busy), 32'd0);
            chk("rs_off_en", 32'(enc_en), 32'd0);
            chk("rs_off_lv", 32'(line_valid), 32'd0);
        end
        tx_enable = 1'b1;
        @(negedge clk);
        chk("rs_rearm_busy", 32'(busy), 32'd1);
        chk("rs_rearm_en", 32'(enc_en), 32'd0);
        chk("rs_rearm_ready", 32'(s_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
